uart_sink: RTL and testbench
============================

# uart_sink

Simulation-side UART receiver that listens on the SoC's `uart_tx` line in the top-level test driver and turns the serial stream into bytes. It oversamples the line, reassembles 8N1 frames (or 8E1 with parity), buffers bytes in a small FIFO and presents them on a valid/ready stream. It also keeps error flags and a byte counter so the bench can detect console output, such as a pass banner, alongside the `success` pin.

## Interface
Parameters:
- `CLK_DIV`, default 868: `clk` cycles per bit; must be ≥ 4.
- `FIFO_DEPTH`, default 16: byte buffer depth; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic rises on its posedge.
- `rstn`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial line from the SoC `uart_tx`; idles high; asynchronous to `clk`.
- `rd_valid`  out  1  FIFO not empty.
- `rd_data`  out  8  head byte; valid only while `rd_valid` is high.
- `rd_ready`  in  1  consumer accepts the head byte when high together with `rd_valid`.
- `frame_err`  out  1  sticky flag: a stop bit was sampled low.
- `parity_err`  out  1  sticky flag: a parity mismatch occurred. Tied 0 without `UART_SINK_PARITY_EN`.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `err_clr`  in  1  synchronous clear of all three sticky flags.
- `byte_count`  out  16  number of bytes accepted into the FIFO; wraps modulo 2^16.

## Operation
- `rxd` passes through a 2-flop synchronizer; `rxs` is the synchronized value. The synchronizer resets to 1.
- Bit timer `tcnt` has width clog2(CLK_DIV). It reloads at each state entry and fires when it reaches 0.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_IDLE.
  - IDLE: `rxs`==0 → START, with `tcnt` = CLK_DIV/2−1.
  - START: when the timer fires, `rxs`==0 → DATA with `tcnt` = CLK_DIV−1 and bit index 0. `rxs`==1 is a glitch → IDLE with no flag.
  - DATA: on each timer fire, shift `rxs` into the shift register LSB-first. After bit 7 → PARITY or STOP.
  - PARITY: on fire, compare `rxs` with even parity of the data byte.
  - STOP: on fire, `rxs`==1 → push the byte (if parity is OK) → IDLE. `rxs`==0 → set `frame_err`, discard the byte → WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs`==1 → IDLE. This prevents re-triggering on a held-low break.
- A parity mismatch sets `parity_err` and discards the byte; STOP is still checked.
- FIFO write: a byte is accepted if not full, or if full and a pop happens in the same cycle. Otherwise it is dropped, `overrun` is set, and `byte_count` is unchanged.
- `byte_count` increments only on an accepted push.
- `err_clr` and a new error in the same cycle: the flag ends up set (set wins).
- Reset mid-frame abandons the frame. The FIFO empties, the FSM goes to IDLE, and all flags and the count go to 0.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `frame_err`=`parity_err`=`overrun`=0, `byte_count`=0, FSM=IDLE.
- Start to sample alignment: data bit k is sampled CLK_DIV/2 + (k+1)·CLK_DIV cycles after the first `rxs` low. These are mid-bit points, ±1 cycle of synchronizer skew.
- Push occurs in the cycle the stop bit is sampled. `rd_valid` and `byte_count` update on the next edge. Total latency from `rxd` stop-bit mid-point to `rd_valid` is 3 cycles: 2 synchronizer cycles plus 1.
- Pop: `rd_valid`&&`rd_ready` advances the head on that edge. `rd_data` is combinational from the FIFO head.
- Back-to-back frames are accepted with no idle bit between the stop bit and the next start bit.

## Configuration
- `UART_SINK_PARITY_EN` defined: frames are 8E1. The PARITY state and `parity_err` logic are present, and a frame takes 11 bit times.
- `UART_SINK_PARITY_EN` undefined: frames are 8N1. The PARITY state is compiled out, `parity_err` is constant 0, and a frame takes 10 bit times.

## Structure
- `uart_sink_pkg`:
  - FSM state enum `uart_sink_state_t`
  - `UART_DATA_BITS`=8
  - function `even_parity(byte)`
- Sub-module `uart_sink_fifo`: synchronous FIFO with a DEPTH parameter, push/pop/full/empty/head, and simultaneous push+pop allowed when full. The FSM, timer and synchronizer stay in `uart_sink`.

## Test plan
- Use CLK_DIV=8. Send 0x55 then 0xA3 in 8N1 → `rd_valid` rises 3 cycles after each stop-bit mid-point with `rd_data`=0x55 then 0xA3, `byte_count`=2, all flags 0.
- A 2-cycle low glitch on idle `rxd` → FSM returns to IDLE, no byte, no flag, `byte_count` stays 0.
- 0x41 with the stop bit forced low, then `rxd` held low 40 cycles, then released → `frame_err`=1, no byte pushed. The next 0x42 is received normally. `err_clr` then clears `frame_err`.
- Hold `rd_ready`=0 and send 17 bytes 0x00..0x10 with FIFO_DEPTH=16 → `overrun`=1, `byte_count`=16. Drain yields 0x00..0x0F.
- FIFO full with `rd_ready`=1 in the exact stop-bit cycle of byte 17 → byte accepted, `overrun` stays 0.
- With `UART_SINK_PARITY_EN`: 0x07 sent with parity 1 (correct) → received. Sent with parity 0 → `parity_err`=1 and no byte. Assert `rstn` low mid-frame → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/uart_sink_pkg.sv
// Shared types and helpers for the uart_sink serial receiver.
// The PARITY state exists only when UART_SINK_PARITY_EN is defined (8E1 framing).
package uart_sink_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_SINK_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } uart_sink_state_t;

    // Value of the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sink_if.sv
// Byte stream from the receiver FIFO: valid/ready handshake with the head byte.
interface uart_sink_if;
    import uart_sink_pkg::*;

    logic                      rd_valid;
    logic [UART_DATA_BITS-1:0] rd_data;
    logic                      rd_ready;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/uart_sink_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is taken when a pop happens on the same edge.
module uart_sink_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             push_ok,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // Head reads as zero when empty so the stream shows a clean value after reset.
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_sink.sv
// Oversampling UART receiver feeding a byte FIFO, with sticky error flags and a byte counter.
// Define UART_SINK_PARITY_EN for 8E1 frames; the default build receives 8N1.
module uart_sink
    import uart_sink_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rxd,
    uart_sink_if.master       rd,
    input  logic              err_clr,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic [15:0]       byte_count
);
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] T_HALF = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLK_DIV - 1);

    logic                      rx_meta;
    logic                      rxs;
    uart_sink_state_t          state, state_nx;
    logic [TW-1:0]             tcnt, tcnt_nx;
    logic [2:0]                bit_idx, bit_idx_nx;
    logic [UART_DATA_BITS-1:0] shreg, shreg_nx;
    logic                      fire;
    logic                      push_req;
    logic                      frame_set;
    logic                      push_ok;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;

    // Two-flop synchronizer; idles high like the line itself.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

`ifdef UART_SINK_PARITY_EN
    logic par_bad, par_bad_nx;
    logic parity_set;
`endif

    assign fire = (tcnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            tcnt    <= '0;
            bit_idx <= '0;
`ifdef UART_SINK_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            tcnt    <= tcnt_nx;
            bit_idx <= bit_idx_nx;
`ifdef UART_SINK_PARITY_EN
            par_bad <= par_bad_nx;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nx;
    end

    always_comb begin
        state_nx   = state;
        tcnt_nx    = fire ? '0 : tcnt - 1'b1;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        push_req   = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_SINK_PARITY_EN
        par_bad_nx = par_bad;
        parity_set = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_nx = ST_START;
                    tcnt_nx  = T_HALF;
                end
            end
            ST_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (fire) begin
                    if (!rxs) begin
                        state_nx   = ST_DATA;
                        tcnt_nx    = T_FULL;
                        bit_idx_nx = '0;
`ifdef UART_SINK_PARITY_EN
                        par_bad_nx = 1'b0;
`endif
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    shreg_nx   = {rxs, shreg[UART_DATA_BITS-1:1]};
                    bit_idx_nx = bit_idx + 1'b1;
                    tcnt_nx    = T_FULL;
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_SINK_PARITY_EN
                        state_nx = ST_PARITY;
`else
                        state_nx = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_SINK_PARITY_EN
            ST_PARITY: begin
                if (fire) begin
                    parity_set = (rxs != even_parity(shreg));
                    par_bad_nx = parity_set;
                    state_nx   = ST_STOP;
                    tcnt_nx    = T_FULL;
                end
            end
`endif
            ST_STOP: begin
                if (fire) begin
                    if (rxs) begin
`ifdef UART_SINK_PARITY_EN
                        push_req = !par_bad;
`else
                        push_req = 1'b1;
`endif
                        state_nx = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_nx  = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low break must end before another start bit is looked for.
                if (rxs) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign pop         = rd.rd_valid && rd.rd_ready;
    assign rd.rd_valid = !fifo_empty;

    uart_sink_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push_req),
        .wdata   (shreg),
        .pop     (pop),
        .push_ok (push_ok),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (rd.rd_data)
    );

    // Sticky flags: a new error in the clearing cycle wins over err_clr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            byte_count <= '0;
        end else begin
            frame_err <= frame_set | (frame_err & ~err_clr);
            overrun   <= (push_req & ~push_ok) | (overrun & ~err_clr);
            if (push_ok) byte_count <= byte_count + 16'd1;
        end
    end

`ifdef UART_SINK_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) parity_err <= 1'b0;
        else       parity_err <= parity_set | (parity_err & ~err_clr);
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sink.sv
// Self-checking bench for uart_sink: serial frames in, byte stream, flags and count checked.
`timescale 1ns/1ps
module tb_uart_sink;
    localparam int CLK_DIV    = 8;
    localparam int FIFO_DEPTH = 16;
`ifdef UART_SINK_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Edges from start-bit drive to rd_valid: stop-bit mid-point plus 3 cycles.
    localparam int LAT_NOM = CLK_DIV * (NBITS - 1) + CLK_DIV / 2 + 1 + 3;

    logic        clk;
    logic        rstn;
    logic        rxd;
    logic        err_clr;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;
    logic [15:0] byte_count;

    uart_sink_if rd_if ();

    uart_sink #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (rxd),
        .rd         (rd_if),
        .err_clr    (err_clr),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .byte_count (byte_count)
    );

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int last_rise = 0;
    int rise_cnt = 0;
    int lat_meas = LAT_NOM - 1;
    int exp_count = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Consumer-side monitor: records every accepted byte and each rd_valid rise.
    always @(negedge clk) begin
        if (rd_if.rd_valid && rd_if.rd_ready) got_q.push_back(rd_if.rd_data);
        if (rd_if.rd_valid && !prev_valid) begin
            last_rise <= edge_cnt;
            rise_cnt  <= rise_cnt + 1;
        end
        prev_valid <= rd_if.rd_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_val,
                              output int start_edge);
        start_edge = edge_cnt;
        rxd = 1'b0;
        repeat (CLK_DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CLK_DIV) tick();
        end
`ifdef UART_SINK_PARITY_EN
        rxd = (^b) ^ ~par_ok;
        repeat (CLK_DIV) tick();
`else
        if (!par_ok) rxd = 1'b1;
`endif
        rxd = stop_val;
        repeat (CLK_DIV) tick();
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; rxd = 1'b1; err_clr = 1'b0; rd_if.rd_ready = 1'b0;
        repeat (3) tick();
        checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", rd_if.rd_valid); end
        checks++; if (rd_if.rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h want 00", rd_if.rd_data); end
        checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {frame_err, parity_err, overrun}); end
        checks++; if (byte_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", byte_count); end
        rstn = 1'b1;
        repeat (2) tick();
        exp_count = 0;
    endtask

    task automatic test_basic();
        int s;
        int r0;
        int d;
        rd_if.rd_ready = 1'b0;
        got_q.delete();
        r0 = rise_cnt;
        send_frame(8'h55, 1'b1, 1'b1, s);
        repeat (4) tick();
        d = last_rise - s;
        checks++; if (rise_cnt != r0 + 1 || d < LAT_NOM - 1 || d > LAT_NOM + 1) begin errors++; $display("FAIL basic_latency0: got %0d rises=%0d want %0d+-1", d, rise_cnt - r0, LAT_NOM); end
        else lat_meas = d;
        checks++; if (rd_if.rd_data !== 8'h55) begin errors++; $display("FAIL basic_data0: got %0h want 55", rd_if.rd_data); end
        rd_if.rd_ready = 1'b1; tick(); rd_if.rd_ready = 1'b0;
        r0 = rise_cnt;
        send_frame(8'hA3, 1'b1, 1'b1, s);
        repeat (4) tick();
        d = last_rise - s;
        checks++; if (rise_cnt != r0 + 1 || d < LAT_NOM - 1 || d > LAT_NOM + 1) begin errors++; $display("FAIL basic_latency1: got %0d rises=%0d want %0d+-1", d, rise_cnt - r0, LAT_NOM); end
        checks++; if (rd_if.rd_data !== 8'hA3) begin errors++; $display("FAIL basic_data1: got %0h want a3", rd_if.rd_data); end
        exp_count += 2;
        checks++; if (byte_count !== 16'(exp_count)) begin errors++; $display("FAIL basic_count: got %0d want %0d", byte_count, exp_count); end
        checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b want 000", {frame_err, parity_err, overrun}); end
        rd_if.rd_ready = 1'b1; tick(); rd_if.rd_ready = 1'b0; tick();
        checks++; if (got_q.size() != 2 || got_q[0] !== 8'h55 || got_q[1] !== 8'hA3) begin errors++; $display("FAIL basic_stream: got %0d bytes want 55,a3", got_q.size()); end
        checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %0b want 0", rd_if.rd_valid); end
    endtask

    task automatic test_glitch();
        int s;
        logic [7:0] b;
        rxd = 1'b0; repeat (2) tick(); rxd = 1'b1;
        repeat (3 * CLK_DIV) tick();
        checks++; if (byte_count !== 16'(exp_count)) begin errors++; $display("FAIL glitch_count: got %0d want %0d", byte_count, exp_count); end
        checks++; if (rd_if.rd_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL glitch_quiet: got valid=%0b ferr=%0b want 0 0", rd_if.rd_valid, frame_err); end
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b1, s);
        repeat (4) tick();
        exp_count++;
        checks++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== b) begin errors++; $display("FAIL glitch_next: got %0b/%0h want 1/%0h", rd_if.rd_valid, rd_if.rd_data, b); end
        rd_if.rd_ready = 1'b1; tick(); rd_if.rd_ready = 1'b0;
    endtask

    task automatic test_frame_err();
        int s;
        send_frame(8'h41, 1'b1, 1'b0, s);
        rxd = 1'b0; repeat (40) tick(); rxd = 1'b1;
        repeat (2 * CLK_DIV) tick();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %0b want 1", frame_err); end
        checks++; if (rd_if.rd_valid !== 1'b0 || byte_count !== 16'(exp_count)) begin errors++; $display("FAIL ferr_nobyte: got valid=%0b count=%0d want 0 %0d", rd_if.rd_valid, byte_count, exp_count); end
        send_frame(8'h42, 1'b1, 1'b1, s);
        repeat (4) tick();
        exp_count++;
        checks++; if (rd_if.rd_data !== 8'h42 || byte_count !== 16'(exp_count)) begin errors++; $display("FAIL ferr_next: got %0h count=%0d want 42 %0d", rd_if.rd_data, byte_count, exp_count); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %0b want 1", frame_err); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr: got %0b want 0", frame_err); end
        rd_if.rd_ready = 1'b1; tick(); rd_if.rd_ready = 1'b0;
    endtask

    task automatic test_random_stream();
        int s;
        int gap;
        logic [7:0] exp_q [$];
        logic [7:0] b;
        rd_if.rd_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            gap = (i < 2) ? 0 : $urandom_range(0, 2);
            send_frame(b, 1'b1, 1'b1, s);
            exp_q.push_back(b);
            repeat (gap * CLK_DIV) tick();
        end
        repeat (6) tick();
        exp_count += 12;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_size: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (byte_count !== 16'(exp_count)) begin errors++; $display("FAIL rand_count: got %0d want %0d", byte_count, exp_count); end
        checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL rand_flags: got %b want 000", {frame_err, parity_err, overrun}); end
        rd_if.rd_ready = 1'b0;
    endtask

    task automatic test_back_to_back_overrun();
        int s;
        rd_if.rd_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i <= FIFO_DEPTH; i++) send_frame(8'(i), 1'b1, 1'b1, s);
        repeat (4) tick();
        exp_count += FIFO_DEPTH;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %0b want 1", overrun); end
        checks++; if (byte_count !== 16'(exp_count)) begin errors++; $display("FAIL ovr_count: got %0d want %0d", byte_count, exp_count); end
        rd_if.rd_ready = 1'b1; repeat (FIFO_DEPTH + 4) tick(); rd_if.rd_ready = 1'b0;
        checks++; if (got_q.size() != FIFO_DEPTH) begin errors++; $display("FAIL ovr_drain_size: got %0d want %0d", got_q.size(), FIFO_DEPTH); end
        for (int i = 0; i < FIFO_DEPTH && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== 8'(i)) begin errors++; $display("FAIL ovr_byte%0d: got %0h want %0h", i, got_q[i], i); end
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %0b want 0", overrun); end
    endtask

    task automatic test_full_pop();
        int s;
        int s_base;
        logic [7:0] exp_q [$];
        logic [7:0] b;
        rd_if.rd_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b1, s);
        end
        repeat (4) tick();
        checks++; if (overrun !== 1'b0 || byte_count !== 16'(exp_count + FIFO_DEPTH)) begin errors++; $display("FAIL full_fill: got ovr=%0b count=%0d want 0 %0d", overrun, byte_count, exp_count + FIFO_DEPTH); end
        b = 8'($urandom);
        exp_q.push_back(b);
        s_base = edge_cnt;
        fork
            send_frame(b, 1'b1, 1'b1, s);
            begin
                while (edge_cnt < s_base + lat_meas - 1) tick();
                rd_if.rd_ready = 1'b1;
                tick();
                rd_if.rd_ready = 1'b0;
            end
        join
        repeat (4) tick();
        exp_count += FIFO_DEPTH + 1;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_pop_ovr: got %0b want 0", overrun); end
        checks++; if (byte_count !== 16'(exp_count)) begin errors++; $display("FAIL full_pop_count: got %0d want %0d", byte_count, exp_count); end
        rd_if.rd_ready = 1'b1; repeat (FIFO_DEPTH + 4) tick(); rd_if.rd_ready = 1'b0;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL full_pop_size: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_pop_byte%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
    endtask

`ifdef UART_SINK_PARITY_EN
    task automatic test_parity();
        int s;
        send_frame(8'h07, 1'b1, 1'b1, s);
        repeat (4) tick();
        exp_count++;
        checks++; if (rd_if.rd_data !== 8'h07 || parity_err !== 1'b0) begin errors++; $display("FAIL par_good: got %0h perr=%0b want 07 0", rd_if.rd_data, parity_err); end
        rd_if.rd_ready = 1'b1; tick(); rd_if.rd_ready = 1'b0;
        send_frame(8'h07, 1'b0, 1'b1, s);
        repeat (4) tick();
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad: got %0b want 1", parity_err); end
        checks++; if (rd_if.rd_valid !== 1'b0 || byte_count !== 16'(exp_count)) begin errors++; $display("FAIL par_drop: got valid=%0b count=%0d want 0 %0d", rd_if.rd_valid, byte_count, exp_count); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_clr: got %0b want 0", parity_err); end
    endtask
`endif

    task automatic test_reset_midframe();
        int s;
        logic [7:0] b;
        rd_if.rd_ready = 1'b0;
        send_frame(8'h10, 1'b1, 1'b0, s);
        rxd = 1'b1; repeat (CLK_DIV) tick();
        send_frame(8'h33, 1'b1, 1'b1, s);
        repeat (4) tick();
        checks++; if (rd_if.rd_valid !== 1'b1 || frame_err !== 1'b1) begin errors++; $display("FAIL mid_pre: got valid=%0b ferr=%0b want 1 1", rd_if.rd_valid, frame_err); end
        rxd = 1'b0; repeat (30) tick();
        rstn = 1'b0; #1;
        checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 8'h00) begin errors++; $display("FAIL mid_stream: got %0b/%0h want 0/00", rd_if.rd_valid, rd_if.rd_data); end
        checks++; if ({frame_err, parity_err, overrun} !== 3'b000 || byte_count !== 16'd0) begin errors++; $display("FAIL mid_state: got flags=%b count=%0d want 000 0", {frame_err, parity_err, overrun}, byte_count); end
        rxd = 1'b1; repeat (3) tick(); rstn = 1'b1; repeat (2) tick();
        exp_count = 0;
        got_q.delete();
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b1, s);
        repeat (4) tick();
        exp_count++;
        checks++; if (rd_if.rd_data !== b || byte_count !== 16'(exp_count)) begin errors++; $display("FAIL mid_after: got %0h count=%0d want %0h %0d", rd_if.rd_data, byte_count, b, exp_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_random_stream();
        test_back_to_back_overrun();
        test_full_pop();
`ifdef UART_SINK_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
